call_return_stack: RTL and testbench

- Parametrised hardware return-address stack for the model CPU; successor to the fixed single-level call/ret save register.
- Sits beside the program counter. The decoder pulses push on CALL with the return address (PC+4) and pulses pop on RET.
- top drives the next PC on RET.
- Adds configurable depth and width, occupancy/full/empty status, sticky error flags, flush, and a debug monitor port in the style of the existing reg*_monitor_signal outputs.

---
 rtl/call_return_stack.sv | 127 ++++++++++++
 tb/tb_call_return_stack.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/call_return_stack.sv
// Return-address stack: push on CALL, pop on RET, registered top,
// occupancy/full/empty status, sticky ovf/unf, flush and a monitor read port.
// Ports: clk, rst (async active-low), push/push_data, pop, flush, clr_err,
//   top, count, empty, full, ovf, unf, mon_sel -> mon_data.
// Option: define CALL_STACK_WRAP_EN to overwrite the oldest entry when full.
module call_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         top,
  output logic [CNT_W-1:0]         count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf,
  input  logic [$clog2(DEPTH)-1:0] mon_sel,
  output logic [WIDTH-1:0]         mon_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    base_q, base_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty_q, full_q;

  logic             we;
  logic [AW-1:0]    waddr;
  logic             ovf_set, unf_set;

  // Physical slots are base-relative so the wrap build can rotate;
  // power-of-two depth makes truncation the modulo.
  logic [AW-1:0] sp_ptr, tp_ptr, nx_ptr, mon_ptr;

  assign sp_ptr  = base_q + cnt_q[AW-1:0];
  assign tp_ptr  = sp_ptr - AW'(1);
  assign nx_ptr  = sp_ptr - AW'(2);
  assign mon_ptr = tp_ptr - mon_sel;

  assign empty_q = (cnt_q == '0);
  assign full_q  = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    cnt_d   = cnt_q;
    base_d  = base_q;
    top_d   = top_q;
    we      = 1'b0;
    waddr   = sp_ptr;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (flush) begin
      cnt_d  = '0;
      base_d = '0;
      top_d  = '0;
    end else if (push && pop && !empty_q) begin
      // tail call: replace the top entry in place
      we    = 1'b1;
      waddr = tp_ptr;
      top_d = push_data;
    end else if (push) begin
      if (!full_q) begin
        we    = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        top_d = push_data;
      end else begin
        ovf_set = 1'b1;
`ifdef CALL_STACK_WRAP_EN
        // when full, the next free slot is the oldest entry
        we     = 1'b1;
        base_d = base_q + AW'(1);
        top_d  = push_data;
`endif
      end
    end else if (pop) begin
      if (!empty_q) begin
        cnt_d = cnt_q - CNT_W'(1);
        top_d = (cnt_q >= CNT_W'(2)) ? mem_q[nx_ptr] : '0;
      end else begin
        unf_set = 1'b1;
      end
    end
    ovf_d = (ovf_q & ~clr_err) | ovf_set;
    unf_d = (unf_q & ~clr_err) | unf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      base_q <= '0;
      top_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
      top_q  <= top_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      if (we) mem_q[waddr] <= push_data;
    end
  end

  always_comb begin
    mon_data = '0;
    if (CNT_W'(mon_sel) < cnt_q) mon_data = mem_q[mon_ptr];
  end

  assign top   = top_q;
  assign count = cnt_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_call_return_stack.sv
// Directed bench for call_return_stack (WIDTH=8, DEPTH=4).
// Immediate assertions with hand-computed expectations.
module tb_call_return_stack;

  logic       clk = 1'b0;
  logic       rst;
  logic       push, pop, flush, clr_err;
  logic [7:0] push_data;
  logic [7:0] top, mon_data;
  logic [2:0] count;
  logic       empty, full, ovf, unf;
  logic [1:0] mon_sel;

  int errs = 0;
  int checks = 0;

  call_return_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_data(push_data),
    .pop(pop), .flush(flush), .clr_err(clr_err),
    .top(top), .count(count),
    .empty(empty), .full(full),
    .ovf(ovf), .unf(unf),
    .mon_sel(mon_sel), .mon_data(mon_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    push = 0; pop = 0; flush = 0; clr_err = 0; push_data = '0;
  endtask

  task automatic step(input logic ps, input logic pp,
                      input logic [7:0] d);
    push = ps; pop = pp; push_data = d;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

  initial begin
    rst = 0; mon_sel = 0; idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_top", top, 8'h00);
    chk("rst_cnt", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_flags", {ovf, unf}, 2'b00);
    chk("rst_mon", mon_data, 8'h00);
    rst = 1;

    // reset mid-push
    step(1, 0, 8'h04);
    chk("pre_rst_top", top, 8'h04);
    push = 1; push_data = 8'h77;
    @(negedge clk);
    rst = 0; #1;
    chk("arst_top", top, 8'h00);
    chk("arst_cnt", count, 3'd0);
    chk("arst_empty", empty, 1'b1);
    @(posedge clk); #1;
    chk("arst_hold_cnt", count, 3'd0);
    chk("arst_hold_top", top, 8'h00);
    idle(); rst = 1;

    // push x3, pop x3
    step(1, 0, 8'h04);
    chk("p1_top", top, 8'h04); chk("p1_cnt", count, 3'd1);
    step(1, 0, 8'h08);
    chk("p2_top", top, 8'h08); chk("p2_cnt", count, 3'd2);
    step(1, 0, 8'h0C);
    chk("p3_top", top, 8'h0C); chk("p3_cnt", count, 3'd3);
    mon_sel = 2; #1;
    chk("p3_mon2", mon_data, 8'h04);
    mon_sel = 0;
    step(0, 1, 8'h00);
    chk("o1_top", top, 8'h08); chk("o1_cnt", count, 3'd2);
    step(0, 1, 8'h00);
    chk("o2_top", top, 8'h04); chk("o2_cnt", count, 3'd1);
    step(0, 1, 8'h00);
    chk("o3_top", top, 8'h00); chk("o3_cnt", count, 3'd0);
    chk("o3_empty", empty, 1'b1);
    chk("o3_unf", unf, 1'b0);

    // fill and overflow
    for (int i = 0; i < 4; i++) step(1, 0, 8'h10 + 8'(i));
    chk("fill_full", full, 1'b1);
    chk("fill_ovf", ovf, 1'b0);
    step(1, 0, 8'h99);
    chk("ovf_full", full, 1'b1);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_cnt", count, 3'd4);
    mon_sel = 3; #1;
`ifdef CALL_STACK_WRAP_EN
    chk("ovf_top", top, 8'h99);
    chk("ovf_mon3", mon_data, 8'h11);
`else
    chk("ovf_top", top, 8'h13);
    chk("ovf_mon3", mon_data, 8'h10);
`endif
    mon_sel = 0;
    flush = 1; step(0, 0, 8'h00);
    chk("fl_cnt", count, 3'd0);
    chk("fl_ovf_kept", ovf, 1'b1);
    clr_err = 1; step(0, 0, 8'h00);
    chk("clr_ovf", ovf, 1'b0);

    // underflow and clear
    step(0, 1, 8'h00);
    chk("unf_set", unf, 1'b1);
    chk("unf_cnt", count, 3'd0);
    clr_err = 1; step(0, 1, 8'h00);
    chk("unf_win", unf, 1'b1);
    clr_err = 1; step(0, 0, 8'h00);
    chk("unf_clr", unf, 1'b0);

    // tail call
    step(1, 0, 8'h08);
    step(1, 1, 8'h20);
    chk("tc_cnt", count, 3'd1);
    chk("tc_top", top, 8'h20);
    step(0, 1, 8'h00);
    chk("tc_pop_top", top, 8'h00);
    step(1, 1, 8'h30);
    chk("tce_cnt", count, 3'd1);
    chk("tce_top", top, 8'h30);
    chk("tce_unf", unf, 1'b0);
    step(0, 1, 8'h00);

    // flush beats push
    step(0, 1, 8'h00);
    chk("pre_fl_unf", unf, 1'b1);
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    chk("pre_fl_cnt", count, 3'd3);
    flush = 1; step(1, 0, 8'h55);
    chk("flp_cnt", count, 3'd0);
    chk("flp_top", top, 8'h00);
    chk("flp_flags", {ovf, unf}, 2'b01);
    for (int s = 0; s < 4; s++) begin
      mon_sel = 2'(s); #1;
      chk("flp_mon", mon_data, 8'h00);
    end
    mon_sel = 0;
    step(1, 0, 8'h66);
    chk("after_fl_top", top, 8'h66);
    mon_sel = 1; #1;
    chk("after_fl_mon1", mon_data, 8'h00);
    mon_sel = 0; #1;
    chk("after_fl_mon0", mon_data, 8'h66);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
